// File: rtl/dca_matrix_wbeat_packer_if.sv
// Row-input and AXI W-output bundle for the matrix W-beat packer.
// The packer uses the slave modport; the upstream/AXI side uses master.
interface dca_matrix_wbeat_packer_if #(
  parameter int BW_ROW_BUFFER = 256,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_AXI_ALEN   = 8
);
  logic                       row_valid;
  logic                       row_ready;
  logic [BW_ROW_BUFFER-1:0]   row_data;
  logic [BW_ROW_BUFFER-1:0]   row_mask;
  logic [BW_AXI_ALEN-1:0]     row_alen;
  logic                       wvalid;
  logic                       wready;
  logic [BW_AXI_DATA-1:0]     wdata;
  logic [BW_AXI_DATA/8-1:0]   wstrb;
  logic                       wlast;
  logic                       busy;
  logic                       overrun_err;

  modport slave (
    input  row_valid, row_data, row_mask, row_alen, wready,
    output row_ready, wvalid, wdata, wstrb, wlast, busy, overrun_err
  );

  modport master (
    output row_valid, row_data, row_mask, row_alen, wready,
    input  row_ready, wvalid, wdata, wstrb, wlast, busy, overrun_err
  );
endinterface

// File: rtl/dca_matrix_wbeat_packer.sv
// Serializes one aligned memory row into AXI W beats with byte strobes and WLAST.
// Holds one row; the next row is taken on the last beat's handshake for gapless bursts.
module dca_matrix_wbeat_packer #(
  parameter int BW_ROW_BUFFER = 256,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_AXI_ALEN   = 8
) (
  input  logic                    clk,
  input  logic                    rstnn,
  dca_matrix_wbeat_packer_if.slave bus
);
  localparam int NUM_SLOT = BW_ROW_BUFFER / BW_AXI_DATA;
  localparam int NUM_BYTE = BW_AXI_DATA / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_ready_en;
  logic                     r_overrun;
  logic [BW_AXI_ALEN-1:0]   r_beat_cnt;
  logic [BW_AXI_ALEN-1:0]   r_alen;
  logic [BW_ROW_BUFFER-1:0] r_data;
  logic [BW_ROW_BUFFER-1:0] r_mask;

  logic                     w_send;
  logic                     w_last;
  logic                     w_beat_hs;
  logic                     w_row_ready;
  logic                     w_row_hs;
  logic                     w_overrun;
  logic [31:0]              w_shift;
  logic [BW_AXI_DATA-1:0]   w_data_slice;
  logic [BW_AXI_DATA-1:0]   w_mask_slice;
  logic [NUM_BYTE-1:0]      w_strb;

  assign w_send      = (r_state == S_SEND);
  assign w_last      = w_send && (r_beat_cnt == r_alen);
  assign w_beat_hs   = w_send && bus.wready;
  // wready reaches row_ready combinationally so a new row lands on the final beat.
  assign w_row_ready = r_ready_en && (!w_send || (bus.wready && w_last));
  assign w_row_hs    = bus.row_valid && w_row_ready;
  assign w_overrun   = w_row_hs && (32'(bus.row_alen) >= 32'(NUM_SLOT));

  // Slots past the end of the row shift out to zero, giving empty overrun beats.
  assign w_shift      = 32'(r_beat_cnt) * 32'(BW_AXI_DATA);
  assign w_data_slice = BW_AXI_DATA'(r_data >> w_shift);
  assign w_mask_slice = BW_AXI_DATA'(r_mask >> w_shift);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_strb = '0;
    for (int b = 0; b < NUM_BYTE; b++) begin
      w_strb[b] = |w_mask_slice[b*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_row_hs) w_state_nxt = S_SEND;
      S_SEND:  if (w_beat_hs && w_last && !w_row_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstnn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      // NOTE: the row holding registers are cleared too, so wdata reads zero straight out of reset.
      r_ready_en <= 1'b0;
      r_overrun  <= 1'b0;
      r_beat_cnt <= '0;
      r_alen     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_overrun  <= w_overrun;
      if (w_row_hs) begin
        r_data     <= bus.row_data;
        r_mask     <= bus.row_mask;
        r_alen     <= bus.row_alen;
        r_beat_cnt <= '0;
      end else if (w_beat_hs && !w_last) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign bus.row_ready   = w_row_ready;
  assign bus.wvalid      = w_send;
  assign bus.busy        = w_send;
  assign bus.wlast       = w_last;
  assign bus.wdata       = w_send ? w_data_slice : '0;
  assign bus.wstrb       = w_send ? w_strb : '0;
  assign bus.overrun_err = r_overrun;
endmodule

// File: tb/tb_dca_matrix_wbeat_packer.sv
// Scoreboard bench for the W-beat packer: rows go in, expected beats are queued
// at acceptance and popped on every W handshake.
module tb_dca_matrix_wbeat_packer;
  localparam int BW_ROW   = 256;
  localparam int BW_DAT   = 32;
  localparam int BW_ALEN  = 8;
  localparam int NUM_SLOT = BW_ROW / BW_DAT;
  localparam int BUDGET   = 4000;

  typedef struct packed {
    logic [BW_DAT-1:0]   data;
    logic [BW_DAT/8-1:0] strb;
    logic                last;
  } beat_t;

  typedef struct packed {
    logic [BW_ROW-1:0]  data;
    logic [BW_ROW-1:0]  mask;
    logic [BW_ALEN-1:0] alen;
  } row_t;

  logic clk   = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  dca_matrix_wbeat_packer_if #(
    .BW_ROW_BUFFER(BW_ROW), .BW_AXI_DATA(BW_DAT), .BW_AXI_ALEN(BW_ALEN)
  ) bus ();

  dca_matrix_wbeat_packer #(
    .BW_ROW_BUFFER(BW_ROW), .BW_AXI_DATA(BW_DAT), .BW_AXI_ALEN(BW_ALEN)
  ) dut (
    .clk  (clk),
    .rstnn(rstnn),
    .bus  (bus)
  );

  beat_t sb[$];
  row_t  rows[$];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic logic [BW_ROW-1:0] rand_row_bits();
    logic [BW_ROW-1:0] v;
    for (int i = 0; i < BW_ROW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic row_t mk_row(logic [BW_ROW-1:0] d, logic [BW_ROW-1:0] m, logic [BW_ALEN-1:0] a);
    row_t r;
    r.data = d;
    r.mask = m;
    r.alen = a;
    return r;
  endfunction

  // Reference model: one beat per alen+1, slots beyond the row are empty.
  function automatic void push_row(row_t r);
    for (int k = 0; k <= int'(r.alen); k++) begin
      beat_t b;
      b.data = '0;
      b.strb = '0;
      b.last = (k == int'(r.alen));
      if (k < NUM_SLOT) begin
        b.data = r.data[k*BW_DAT +: BW_DAT];
        for (int j = 0; j < BW_DAT/8; j++) b.strb[j] = |r.mask[k*BW_DAT + j*8 +: 8];
      end
      sb.push_back(b);
    end
  endfunction

  function automatic logic ready_for(int mode, int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_row(row_t r);
    bus.row_data  = r.data;
    bus.row_mask  = r.mask;
    bus.row_alen  = r.alen;
    bus.row_valid = 1'b1;
  endtask

  // Offers every row in the queue, drives wready per mode, and checks beats,
  // stall stability, busy, overrun timing and acceptance points.
  task automatic run_traffic(input string tag, input int mode, input int exp_beats, output int span);
    row_t  cur;
    beat_t exp_b, held;
    bit    acc_prev, ovr_exp, stall_prev, beat_hs, row_hs, popped_last, exp_busy;
    int    beats, cyc, first_c, last_c;
    acc_prev = 0; ovr_exp = 0; stall_prev = 0; beats = 0; cyc = 0;
    first_c = -1; last_c = -1; held = '0; cur = '0;
    bus.wready = ready_for(mode, 0);
    if (rows.size() > 0) begin
      cur = rows.pop_front();
      drive_row(cur);
    end
    while ((sb.size() > 0 || bus.row_valid || acc_prev) && cyc < BUDGET) begin
      @(negedge clk);
      n_total++;
      if (bus.overrun_err !== ovr_exp)
        $display("FAIL %s overrun_err cyc%0d got %b want %b", tag, cyc, bus.overrun_err, ovr_exp);
      else n_pass++;
      exp_busy = (sb.size() > 0);
      n_total++;
      if (bus.busy !== exp_busy || bus.wvalid !== exp_busy)
        $display("FAIL %s busy/wvalid cyc%0d got %b/%b want %b", tag, cyc, bus.busy, bus.wvalid, exp_busy);
      else n_pass++;
      if (stall_prev) begin
        n_total++;
        if (bus.wvalid !== 1'b1 || {bus.wdata, bus.wstrb, bus.wlast} !== held)
          $display("FAIL %s stall_hold cyc%0d got %h/%h/%b want %h/%h/%b", tag, cyc,
                   bus.wdata, bus.wstrb, bus.wlast, held.data, held.strb, held.last);
        else n_pass++;
      end
      beat_hs     = (bus.wvalid === 1'b1) && bus.wready;
      popped_last = 0;
      if (beat_hs) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL %s extra_beat cyc%0d got wdata %h want no beat", tag, cyc, bus.wdata);
        end else begin
          exp_b       = sb.pop_front();
          popped_last = exp_b.last;
          if ({bus.wdata, bus.wstrb, bus.wlast} !== exp_b)
            $display("FAIL %s beat%0d got wdata %h wstrb %b wlast %b want %h %b %b", tag, beats,
                     bus.wdata, bus.wstrb, bus.wlast, exp_b.data, exp_b.strb, exp_b.last);
          else n_pass++;
          if (exp_b.last) begin
            n_total++;
            if (bus.row_ready !== 1'b1)
              $display("FAIL %s row_ready_on_last beat%0d got %b want 1", tag, beats, bus.row_ready);
            else n_pass++;
          end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        beats++;
      end
      stall_prev = (bus.wvalid === 1'b1) && !bus.wready;
      held       = '{bus.wdata, bus.wstrb, bus.wlast};
      row_hs     = bus.row_valid && (bus.row_ready === 1'b1);
      if (row_hs && bus.wvalid === 1'b1) begin
        n_total++;
        if (!popped_last)
          $display("FAIL %s early_accept cyc%0d got accept want only on last handshake", tag, cyc);
        else n_pass++;
      end
      ovr_exp  = row_hs && (cur.alen >= BW_ALEN'(NUM_SLOT));
      acc_prev = row_hs;
      if (row_hs) push_row(cur);
      @(posedge clk);
      #1;
      if (row_hs) begin
        if (rows.size() > 0) begin
          cur = rows.pop_front();
          drive_row(cur);
        end else begin
          bus.row_valid = 1'b0;
        end
      end
      cyc++;
      bus.wready = ready_for(mode, cyc);
    end
    bus.row_valid = 1'b0;
    n_total++;
    if (cyc >= BUDGET) $display("FAIL %s timeout got %0d beats want %0d", tag, beats, exp_beats);
    else n_pass++;
    n_total++;
    if (beats != exp_beats) $display("FAIL %s beat_count got %0d want %0d", tag, beats, exp_beats);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.wvalid !== 1'b0 || bus.overrun_err !== ovr_exp)
      $display("FAIL %s idle_after got wvalid %b ovr %b want 0 %b", tag, bus.wvalid, bus.overrun_err, ovr_exp);
    else n_pass++;
    span = (first_c < 0) ? 0 : (last_c - first_c + 1);
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    #3;
    n_total++;
    if ({bus.wvalid, bus.wlast, bus.busy, bus.overrun_err, bus.row_ready} !== 5'b0 ||
        bus.wdata !== '0 || bus.wstrb !== '0)
      $display("FAIL reset_outputs got v%b l%b b%b o%b r%b d%h s%b want all 0", bus.wvalid, bus.wlast,
               bus.busy, bus.overrun_err, bus.row_ready, bus.wdata, bus.wstrb);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rstnn = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if (bus.row_ready !== 1'b1 || bus.wvalid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_release got ready %b wvalid %b busy %b want 1 0 0", bus.row_ready, bus.wvalid, bus.busy);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    logic [BW_ROW-1:0] d, m;
    int span;
    d = rand_row_bits();
    m = rand_row_bits();
    d[31:0] = 32'hA5A5_1234;
    m[31:0] = 32'h0000_FFFF;
    rows.push_back(mk_row(d, m, 8'd0));
    @(posedge clk); #1;
    run_traffic("single", 0, 1, span);
  endtask

  task automatic test_full_row();
    logic [BW_ROW-1:0] d;
    int span;
    for (int k = 0; k < NUM_SLOT; k++) d[k*BW_DAT +: BW_DAT] = BW_DAT'(k + 1);
    rows.push_back(mk_row(d, '1, 8'd7));
    @(posedge clk); #1;
    run_traffic("full_row", 1, 8, span);
  endtask

  task automatic test_back_to_back();
    int span;
    rows.push_back(mk_row(rand_row_bits(), rand_row_bits(), 8'd7));
    rows.push_back(mk_row(rand_row_bits(), rand_row_bits(), 8'd1));
    @(posedge clk); #1;
    run_traffic("b2b", 0, 10, span);
    n_total++;
    if (span != 10) $display("FAIL b2b gapless got span %0d want 10", span);
    else n_pass++;
  endtask

  task automatic test_sub_byte();
    logic [BW_ROW-1:0] m;
    int span;
    m = '0;
    m[31:0] = 32'h0100_0008;
    rows.push_back(mk_row(rand_row_bits(), m, 8'd0));
    @(posedge clk); #1;
    run_traffic("sub_byte", 0, 1, span);
  endtask

  task automatic test_overrun();
    int span;
    rows.push_back(mk_row(rand_row_bits(), '1, 8'd9));
    @(posedge clk); #1;
    run_traffic("overrun", 0, 10, span);
  endtask

  task automatic test_zero_mask();
    int span;
    rows.push_back(mk_row(rand_row_bits(), '0, 8'd2));
    @(posedge clk); #1;
    run_traffic("zero_mask", 1, 3, span);
  endtask

  task automatic test_long_burst();
    int span;
    rows.push_back(mk_row(rand_row_bits(), rand_row_bits(), 8'd255));
    @(posedge clk); #1;
    run_traffic("long_burst", 0, 256, span);
  endtask

  task automatic test_random_rows();
    int span, total;
    logic [BW_ALEN-1:0] a;
    total = 0;
    for (int i = 0; i < 6; i++) begin
      a = BW_ALEN'($urandom_range(0, 10));
      total += int'(a) + 1;
      rows.push_back(mk_row(rand_row_bits(), rand_row_bits(), a));
    end
    @(posedge clk); #1;
    run_traffic("random_rows", 2, total, span);
  endtask

  task automatic test_reset_mid_burst();
    row_t r;
    int span;
    r = mk_row(rand_row_bits(), '1, 8'd7);
    @(posedge clk); #1;
    drive_row(r);
    bus.wready = 1'b1;
    @(posedge clk); #1;
    bus.row_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.wready = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.wvalid !== 1'b1 || bus.wdata !== r.data[3*BW_DAT +: BW_DAT])
      $display("FAIL mid_reset beat3 got v%b %h want 1 %h", bus.wvalid, bus.wdata, r.data[3*BW_DAT +: BW_DAT]);
    else n_pass++;
    #2 rstnn = 1'b0;
    #1;
    n_total++;
    if (bus.wvalid !== 1'b0 || bus.wlast !== 1'b0 || bus.busy !== 1'b0 || bus.wdata !== '0)
      $display("FAIL mid_reset drop got v%b l%b b%b d%h want 0 0 0 0", bus.wvalid, bus.wlast, bus.busy, bus.wdata);
    else n_pass++;
    @(posedge clk); #1 rstnn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (bus.row_ready !== 1'b1) $display("FAIL mid_reset row_ready got %b want 1", bus.row_ready);
    else n_pass++;
    sb.delete();
    rows.delete();
    rows.push_back(mk_row(rand_row_bits(), rand_row_bits(), 8'd3));
    @(posedge clk); #1;
    run_traffic("post_reset", 0, 4, span);
  endtask

  initial begin
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.row_mask  = '0;
    bus.row_alen  = '0;
    bus.wready    = 1'b0;
    test_reset();
    test_single_beat();
    test_full_row();
    test_back_to_back();
    test_sub_byte();
    test_overrun();
    test_zero_mask();
    test_long_burst();
    test_random_rows();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
